// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter: N requesters share one synchronous FIFO write port.
// Define FIFO_WR_ARB_BURST_EN to lock the grant onto one requester for up to BURST_LEN beats.
module fifo_wr_arbiter #(
  parameter int DATA_WIDTH = 512,
  parameter int NUM_REQ    = 4,
  parameter int BURST_LEN  = 4
) (
  input  logic                          clk,
  input  logic                          i_rst,
  input  logic [NUM_REQ-1:0]            i_req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data,
  output logic [NUM_REQ-1:0]            o_req_ready,
  output logic                          o_fifo_wen,
  output logic [DATA_WIDTH-1:0]         o_fifo_data,
  input  logic                          i_fifo_full,
  output logic [$clog2(NUM_REQ)-1:0]    o_grant_id,
  output logic                          o_locked
);

  localparam int IDW = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 16 || BURST_LEN < 2 || BURST_LEN > 256) begin : g_param_chk
    $error("fifo_wr_arbiter: NUM_REQ or BURST_LEN out of range");
  end

  function automatic logic [IDW-1:0] wrap_inc(input logic [IDW-1:0] idx);
    if (int'(idx) == NUM_REQ - 1) return '0;
    return idx + IDW'(1);
  endfunction

  // Returns {found, index} of the first set bit at or after base, wrapping.
  function automatic logic [IDW:0] rr_pick(input logic [NUM_REQ-1:0] vld,
                                           input logic [IDW-1:0]     base);
    logic           found;
    logic [IDW-1:0] idx;
    logic [IDW-1:0] pick;
    found = 1'b0;
    pick  = '0;
    idx   = base;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && vld[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
      idx = wrap_inc(idx);
    end
    return {found, pick};
  endfunction

  logic [IDW-1:0]     prio_q, prio_d;
  logic [NUM_REQ-1:0] cand;
  logic [IDW-1:0]     base;
  logic [IDW-1:0]     sel;
  logic               any_vld;
  logic               xfer;

`ifdef FIFO_WR_ARB_BURST_EN
  localparam int CNTW = $clog2(BURST_LEN + 1);

  typedef enum logic {ARB, LOCK} state_t;

  state_t             state_q, state_d;
  logic [IDW-1:0]     owner_q, owner_d;
  logic [CNTW-1:0]    cnt_q, cnt_d;
  logic [NUM_REQ-1:0] owner_oh;
  logic               owner_hold;

  // While locked, only the owner competes; once it drops valid, everyone else
  // competes starting just past the owner.
  always_comb begin
    owner_oh          = '0;
    owner_oh[owner_q] = 1'b1;
    owner_hold        = (state_q == LOCK) && i_req_valid[owner_q];
    cand              = i_req_valid;
    base              = prio_q;
    if (state_q == LOCK) begin
      if (owner_hold) begin
        cand = owner_oh;
        base = owner_q;
      end else begin
        cand = i_req_valid & ~owner_oh;
        base = wrap_inc(owner_q);
      end
    end
    {any_vld, sel} = rr_pick(cand, base);
    xfer           = any_vld && !i_fifo_full && !i_rst;
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      state_q <= ARB;
      prio_q  <= '0;
      owner_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
    end
  end

  // State only moves on a transfer, so backpressure and idle cycles hold everything.
  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    if (xfer) begin
      case (state_q)
        ARB: begin
          state_d = LOCK;
          owner_d = sel;
          cnt_d   = CNTW'(1);
        end
        LOCK: begin
          if (owner_hold) begin
            if (int'(cnt_q) + 1 == BURST_LEN) begin
              state_d = ARB;
              prio_d  = wrap_inc(owner_q);
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CNTW'(1);
            end
          end else begin
            state_d = ARB;
            prio_d  = wrap_inc(sel);
            cnt_d   = '0;
          end
        end
        default: state_d = ARB;
      endcase
    end
  end

  always_comb o_locked = (state_q == LOCK) && !i_rst;
`else
  always_comb begin
    cand           = i_req_valid;
    base           = prio_q;
    {any_vld, sel} = rr_pick(cand, base);
    xfer           = any_vld && !i_fifo_full && !i_rst;
    prio_d         = xfer ? wrap_inc(sel) : prio_q;
  end

  always_ff @(posedge clk) begin
    if (i_rst) prio_q <= '0;
    else       prio_q <= prio_d;
  end

  always_comb o_locked = 1'b0;
`endif

  always_comb begin
    o_req_ready = '0;
    o_fifo_wen  = xfer;
    o_fifo_data = '0;
    o_grant_id  = '0;
    if (xfer) begin
      o_req_ready[sel] = 1'b1;
      o_fifo_data      = i_req_data[int'(sel)*DATA_WIDTH +: DATA_WIDTH];
      o_grant_id       = sel;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: driver predicts with a queue-based model,
// monitor compares on the falling edge. Honours FIFO_WR_ARB_BURST_EN if defined.
module tb_fifo_wr_arbiter;
  localparam int DW = 32;
  localparam int N  = 4;
  localparam int BL = 4;

  typedef struct packed {
    logic         wen;
    logic [N-1:0] ready;
    logic         locked;
  } ctrl_t;

  typedef struct packed {
    logic [1:0]    gid;
    logic [DW-1:0] data;
  } wr_t;

  logic            clk = 1'b0;
  logic            i_rst;
  logic [N-1:0]    i_req_valid;
  logic [N*DW-1:0] i_req_data;
  logic [N-1:0]    o_req_ready;
  logic            o_fifo_wen;
  logic [DW-1:0]   o_fifo_data;
  logic            i_fifo_full;
  logic [1:0]      o_grant_id;
  logic            o_locked;

  fifo_wr_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(N), .BURST_LEN(BL)) dut (
    .clk         (clk),
    .i_rst       (i_rst),
    .i_req_valid (i_req_valid),
    .i_req_data  (i_req_data),
    .o_req_ready (o_req_ready),
    .o_fifo_wen  (o_fifo_wen),
    .o_fifo_data (o_fifo_data),
    .i_fifo_full (i_fifo_full),
    .o_grant_id  (o_grant_id),
    .o_locked    (o_locked)
  );

  always #5 clk = ~clk;

  int    total = 0;
  int    bad   = 0;
  ctrl_t ctrl_q[$];
  wr_t   wr_q[$];
  int    gid_log[$];

  // Reference state: next search start, lock flag, owner, beats written by owner.
  int m_prio = 0, m_owner = 0, m_beats = 0;
  bit m_lock = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
    end
  endtask

  task automatic predict();
    ctrl_t        e;
    wr_t          w;
    logic [N-1:0] c;
    int           start, pick;
    bit           found;
    e = '0; w = '0; pick = 0; found = 0;
    if (!i_rst) begin
      e.locked = m_lock;
      c = i_req_valid;
      start = m_prio;
      if (m_lock) begin
        if (i_req_valid[m_owner]) begin
          c = '0; c[m_owner] = 1'b1; start = m_owner;
        end else begin
          c[m_owner] = 1'b0; start = (m_owner + 1) % N;
        end
      end
      for (int k = 0; k < N; k++)
        if (!found && c[(start + k) % N]) begin found = 1; pick = (start + k) % N; end
      if (found && !i_fifo_full) begin
        e.wen = 1'b1;
        e.ready[pick] = 1'b1;
        w.gid  = 2'(pick);
        w.data = i_req_data[pick*DW +: DW];
        wr_q.push_back(w);
      end
    end
    ctrl_q.push_back(e);
    if (i_rst) begin
      m_prio = 0; m_lock = 0; m_owner = 0; m_beats = 0;
    end else if (e.wen) begin
`ifdef FIFO_WR_ARB_BURST_EN
      if (!m_lock) begin
        m_lock = 1; m_owner = pick; m_beats = 1;
      end else if (pick == m_owner) begin
        m_beats++;
        if (m_beats == BL) begin m_lock = 0; m_prio = (m_owner + 1) % N; end
      end else begin
        m_lock = 0; m_prio = (pick + 1) % N;
      end
`else
      m_prio = (pick + 1) % N;
`endif
    end
  endtask

  task automatic step(input logic [N-1:0] v, input bit full, input bit rst);
    i_rst       = rst;
    i_req_valid = v;
    i_fifo_full = full;
    for (int k = 0; k < N; k++) i_req_data[k*DW +: DW] = $urandom;
    predict();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    ctrl_t e;
    wr_t   w;
    if (ctrl_q.size() > 0) begin
      e = ctrl_q.pop_front();
      chk("wen", 64'(o_fifo_wen), 64'(e.wen));
      chk("ready", 64'(o_req_ready), 64'(e.ready));
      chk("locked", 64'(o_locked), 64'(e.locked));
      if (o_fifo_wen) begin
        gid_log.push_back(int'(o_grant_id));
        if (wr_q.size() == 0) begin
          chk("unexpected_write", 64'(1), 64'(0));
        end else begin
          w = wr_q.pop_front();
          chk("grant_id", 64'(o_grant_id), 64'(w.gid));
          chk("fifo_data", 64'(o_fifo_data), 64'(w.data));
        end
      end else begin
        chk("idle_grant_id", 64'(o_grant_id), 64'(0));
        chk("idle_fifo_data", 64'(o_fifo_data), 64'(0));
      end
    end
  end

  int exp_rr[8];

  initial begin
    i_rst = 1'b1; i_req_valid = '0; i_fifo_full = 1'b0; i_req_data = '0;
    @(posedge clk);
    #1;
    // Reset with everything requesting: outputs must stay zero.
    step(4'b1111, 0, 1);
    step(4'b1111, 0, 1);
    // Continuous requests from all four.
    gid_log.delete();
    for (int i = 0; i < 8; i++) step(4'b1111, 0, 0);
`ifdef FIFO_WR_ARB_BURST_EN
    exp_rr = '{0, 0, 0, 0, 1, 1, 1, 1};
`else
    exp_rr = '{0, 1, 2, 3, 0, 1, 2, 3};
`endif
    chk("rr_count", 64'(gid_log.size()), 64'(8));
    for (int i = 0; i < 8 && i < gid_log.size(); i++) chk("rr_seq", 64'(gid_log[i]), 64'(exp_rr[i]));
    // Full backpressure on requester 2.
    step(4'b0000, 0, 1);
    for (int i = 0; i < 3; i++) step(4'b0100, 1, 0);
    gid_log.delete();
    step(4'b0100, 0, 0);
    chk("full_release_cnt", 64'(gid_log.size()), 64'(1));
    if (gid_log.size() > 0) chk("full_release_gid", 64'(gid_log[0]), 64'(2));
    step(4'b0000, 0, 0);
    // Wrap-around: drive the pointer to 3, then only 0 and 1 request.
    step(4'b0000, 0, 1);
`ifdef FIFO_WR_ARB_BURST_EN
    for (int i = 0; i < BL; i++) step(4'b0100, 0, 0);
`else
    step(4'b0100, 0, 0);
`endif
    gid_log.delete();
    for (int i = 0; i < 6; i++) step(4'b0011, 0, 0);
    if (gid_log.size() > 0) chk("wrap_first_gid", 64'(gid_log[0]), 64'(0));
    // Early release: owner 0 drops while 3 waits.
    step(4'b0000, 0, 1);
    step(4'b1001, 0, 0);
    step(4'b1001, 0, 0);
    step(4'b1000, 0, 0);
    step(4'b0000, 0, 0);
    // Reset in the middle of a burst.
    step(4'b0000, 0, 1);
    step(4'b1111, 0, 0);
    step(4'b1111, 0, 0);
    step(4'b1111, 0, 1);
    step(4'b1111, 0, 1);
    gid_log.delete();
    step(4'b1111, 0, 0);
    if (gid_log.size() > 0) chk("post_reset_gid", 64'(gid_log[0]), 64'(0));
    // Random traffic with occasional backpressure and reset.
    for (int i = 0; i < 2000; i++)
      step(4'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0), ($urandom_range(0, 63) == 0));
    step(4'b0000, 0, 0);
    @(negedge clk);
    #1;
    chk("wr_queue_drained", 64'(wr_q.size()), 64'(0));
    chk("ctrl_queue_drained", 64'(ctrl_q.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 SHALL provide parameter DATA_WIDTH, default 512, width of one data beat.
REQ-002 SHALL provide parameter NUM_REQ, default 4, number of requesters; legal range 2..16.
REQ-003 SHALL provide parameter BURST_LEN, default 4, maximum beats per locked grant; legal range 2..256.
REQ-004 SHALL provide port clk, input, 1 bit, rising-edge clock.
REQ-005 SHALL provide port i_rst, input, 1 bit, reset; synchronous, active-high.
REQ-006 SHALL provide port i_req_valid, input, NUM_REQ bits, per-requester beat valid.
REQ-007 SHALL provide port i_req_data, input, NUM_REQ*DATA_WIDTH bits, requester k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-008 SHALL provide port o_req_ready, output, NUM_REQ bits, per-requester beat accepted this cycle when valid.
REQ-009 SHALL provide port o_fifo_wen, output, 1 bit, write enable to the shared synchronous FIFO.
REQ-010 SHALL provide port o_fifo_data, output, DATA_WIDTH bits, write data to the FIFO.
REQ-011 SHALL provide port i_fifo_full, input, 1 bit, FIFO full flag.
REQ-012 SHALL provide port o_grant_id, output, clog2(NUM_REQ) bits, index of the requester written this cycle.
REQ-013 SHALL provide port o_locked, output, 1 bit, high while the block is in LOCK state.

Function
REQ-014 SHALL select the first requester with valid high, searching upward from priority pointer r_prio with wrap-around past NUM_REQ-1 to 0.
REQ-015 SHALL assert o_req_ready only for the selected requester, and only while i_fifo_full is low; all other ready bits are low.
REQ-016 SHALL treat a transfer as selected valid & ready, and SHALL assert o_fifo_wen in the same cycle (zero latency, combinational).
REQ-017 SHALL drive o_fifo_data with the selected requester's slice and o_grant_id with its index during a transfer, and all-zero otherwise.
REQ-018 SHALL never assert o_fifo_wen while i_fifo_full is high; r_prio, state and beat count hold in that cycle.
REQ-019 SHALL, on a transfer in ARB state, set r_prio to (granted index + 1) mod NUM_REQ.
REQ-020 SHALL, with no valid requesters, keep all outputs low and hold all state.
REQ-021 SHALL be at most one transfer per cycle.

Reset
REQ-022 SHALL, on a clock edge with i_rst high, set r_prio to 0, state to ARB, beat count to 0 and owner to 0.
REQ-023 SHALL force o_req_ready, o_fifo_wen, o_fifo_data, o_grant_id and o_locked to 0 while i_rst is high, including when reset is asserted mid-burst.

Configuration
REQ-024 SHALL compile burst locking in only when macro FIFO_WR_ARB_BURST_EN is defined.
REQ-025 SHALL, without FIFO_WR_ARB_BURST_EN, stay permanently in ARB, re-arbitrate every beat, and hold o_locked at 0.
REQ-026 SHALL, with FIFO_WR_ARB_BURST_EN, move ARB->LOCK on a transfer, recording owner = granted index and beat count = 1; r_prio is not updated on this transition.
REQ-027 SHALL, in LOCK, select only the owner while the owner is valid, and increment the beat count on each owner transfer.
REQ-028 SHALL, in LOCK, return to ARB with r_prio = owner+1 on the owner transfer that makes the beat count equal BURST_LEN.
REQ-029 SHALL, in LOCK with owner valid low, arbitrate that same cycle as in ARB starting from owner+1, excluding the owner, and return to ARB. A transfer in that cycle follows REQ-019 and does not re-enter LOCK.
REQ-030 SHALL, in LOCK with i_fifo_full high, hold the lock and beat count unchanged.

Verification
REQ-031 SHALL cover round-robin: all 4 requesters valid continuously, full low, macro off -> grant_id sequence 0,1,2,3,0 with one write per cycle.
REQ-032 SHALL cover full backpressure: requester 2 valid, i_fifo_full high for 3 cycles -> no wen and ready=0 for those 3 cycles; write with grant_id=2 on the first cycle full is low.
REQ-033 SHALL cover wrap-around: r_prio=3 and only requesters 0 and 1 valid -> requester 0 is granted first, then requester 1.
REQ-034 SHALL cover burst: macro on, BURST_LEN=4, requesters 0 and 1 valid -> four writes with grant_id 0, then grant_id 1, with o_locked high during the owner burst.
REQ-035 SHALL cover early release: macro on, owner 0 drops valid after 2 beats while requester 3 is valid -> requester 3 is written in the cycle valid drops, and o_locked is low on the next cycle.
REQ-036 SHALL cover reset mid-burst: i_rst high during LOCK -> all outputs are 0 during reset; after reset, requester 0 wins when all requesters are valid.
